// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: pipeline (A) writes take priority over a
// FIFO of long-latency (B) writes, with squash of stale B entries and an anti-starvation force.
module regfile_wb_arbiter #(
    parameter int unsigned B_DEPTH  = 2,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     a_valid,
    output logic                     a_ready,
    input  logic [4:0]               a_addr,
    input  logic [31:0]              a_data,
    input  logic                     b_valid,
    output logic                     b_ready,
    input  logic [4:0]               b_addr,
    input  logic [31:0]              b_data,
    output logic                     rf_we,
    output logic [4:0]               rf_wa,
    output logic [31:0]              rf_wd,
    output logic [$clog2(B_DEPTH):0] b_pending
);
    localparam int unsigned AW = $clog2(B_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned WW = $clog2(MAX_WAIT) + 1;

    typedef enum logic [1:0] {IDLE, DRAIN, FORCE_B} state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      rd_ptr, wr_ptr;
    logic [CW-1:0]      count_q, count_d;
    logic [WW-1:0]      wait_q, wait_d;
    logic [B_DEPTH-1:0] live_q;
    logic [4:0]         addr_mem [B_DEPTH];
    logic [31:0]        data_mem [B_DEPTH];

    logic        head_valid, head_live, a_acc, push, pop, grant_b, starve;
    logic [4:0]  head_addr;
    logic [31:0] head_data;

    always_comb begin
        head_valid = (count_q != '0);
        head_addr  = addr_mem[rd_ptr];
        head_data  = data_mem[rd_ptr];
        head_live  = head_valid && live_q[rd_ptr];
        a_ready    = (state_q != FORCE_B);
        b_ready    = (count_q < CW'(B_DEPTH));
        a_acc      = a_valid && a_ready;
        push       = b_valid && b_ready;
        grant_b    = head_live && ((state_q == FORCE_B) || !a_valid);
        // A dead head leaves regardless of who owns the write port this cycle.
        pop        = head_valid && (grant_b || !live_q[rd_ptr]);
        starve     = head_live && !grant_b;
        count_d    = count_q + CW'(push) - CW'(pop);
        b_pending  = count_q;

        wait_d = wait_q;
        if (!head_valid || pop)
            wait_d = '0;
        else if (starve)
            wait_d = wait_q + WW'(1);

        state_d = IDLE;
        if (starve && (wait_q == WW'(MAX_WAIT - 1)))
            state_d = FORCE_B;
        else if (count_d != '0)
            state_d = DRAIN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            wait_q  <= '0;
            live_q  <= '0;
            rf_we   <= 1'b0;
            rf_wa   <= '0;
            rf_wd   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            wait_q  <= wait_d;
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push)
                wr_ptr <= wr_ptr + AW'(1);

            // Squash older entries hit by A; the entry pushed this cycle is younger and survives.
            for (int unsigned i = 0; i < B_DEPTH; i++) begin
                if (a_acc && (a_addr != '0) && (addr_mem[i] == a_addr))
                    live_q[i] <= 1'b0;
            end
            if (push)
                live_q[wr_ptr] <= 1'b1;

            rf_we <= 1'b0;
            if (grant_b) begin
                rf_we <= (head_addr != '0);
                if (head_addr != '0) begin
                    rf_wa <= head_addr;
                    rf_wd <= head_data;
                end
            end else if (a_acc) begin
                rf_we <= (a_addr != '0);
                if (a_addr != '0) begin
                    rf_wa <= a_addr;
                    rf_wd <= a_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= b_addr;
            data_mem[wr_ptr] <= b_data;
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, corner-case sequences,
// and random traffic against a queue-based reference model.
module tb_regfile_wb_arbiter;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned MAXW  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, a_ready, b_valid, b_ready, rf_we;
    logic [4:0]  a_addr, b_addr, rf_wa;
    logic [31:0] a_data, b_data, rf_wd;
    logic [1:0]  b_pending;

    regfile_wb_arbiter #(.B_DEPTH(DEPTH), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .b_pending(b_pending)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue of {addr,data,live}, counted refusals.
    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        live;
    } ent_t;

    ent_t        q[$];
    bit          m_force;
    int          m_refused;
    logic        m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    logic [31:0] wlog[$];

    task automatic model_reset();
        q.delete();
        m_force   = 0;
        m_refused = 0;
        m_we      = 1'b0;
        m_wa      = '0;
        m_wd      = '0;
    endtask

    task automatic m_write(input logic [4:0] addr, input logic [31:0] data);
        m_we = (addr != 0);
        if (addr != 0) begin
            m_wa = addr;
            m_wd = data;
        end
    endtask

    task automatic step(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic bv, input logic [4:0] ba, input logic [31:0] bd);
        ent_t h;
        bit   force_now, a_acc, push;
        int   sz;
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        #4;
        sz        = q.size();
        force_now = m_force;
        m_force   = 0;
        chk("a_ready", a_ready, !force_now);
        chk("b_ready", b_ready, sz < DEPTH);
        a_acc = av && !force_now;
        push  = bv && (sz < DEPTH);
        m_we  = 1'b0;
        if (sz == 0) begin
            m_refused = 0;
            if (a_acc) m_write(aa, ad);
        end else begin
            h = q[0];
            if (force_now) begin
                void'(q.pop_front());
                m_refused = 0;
                if (h.live) m_write(h.addr, h.data);
            end else if (!h.live) begin
                void'(q.pop_front());
                m_refused = 0;
                if (a_acc) m_write(aa, ad);
            end else if (av) begin
                m_write(aa, ad);
                m_refused++;
                if (m_refused == MAXW) begin
                    m_force   = 1;
                    m_refused = 0;
                end
            end else begin
                void'(q.pop_front());
                m_refused = 0;
                m_write(h.addr, h.data);
            end
        end
        if (a_acc && aa != 0)
            foreach (q[i]) if (q[i].addr == aa) q[i].live = 1'b0;
        if (push) q.push_back('{ba, bd, 1'b1});
        @(posedge clk); #1;
        chk("rf_we", rf_we, m_we);
        if (m_we) begin
            chk("rf_wa", rf_wa, m_wa);
            chk("rf_wd", rf_wd, m_wd);
        end
        chk("b_pending", b_pending, q.size());
        if (rf_we) wlog.push_back(rf_wd);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a_valid = 0; a_addr = 0; a_data = 0;
        b_valid = 0; b_addr = 0; b_data = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", rf_we, 0);
        chk("rst_wa", rf_wa, 0);
        chk("rst_wd", rf_wd, 0);
        chk("rst_pend", b_pending, 0);
        chk("rst_a_ready", a_ready, 1);
        chk("rst_b_ready", b_ready, 1);
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  ba;
        logic [31:0] bd;
        logic        ar, br, we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [1:0]  pend;
    } vec_t;

    vec_t tbl[13];

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] bw[$];
        bit          accepted;

        // A-only, B-only, then starvation of B head addr 3 by A addr 9.
        tbl[0]  = '{1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,  1, 1, 1, 5'd5, 32'hDEADBEEF, 2'd0};
        tbl[1]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  1, 1, 0, 5'd5, 32'hDEADBEEF, 2'd0};
        tbl[2]  = '{0, 5'd0, 32'h0,        1, 5'd7, 32'h11, 1, 1, 0, 5'd5, 32'hDEADBEEF, 2'd1};
        tbl[3]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  1, 1, 1, 5'd7, 32'h11,       2'd0};
        tbl[4]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  1, 1, 0, 5'd7, 32'h11,       2'd0};
        tbl[5]  = '{1, 5'd9, 32'h100,      1, 5'd3, 32'h33, 1, 1, 1, 5'd9, 32'h100,      2'd1};
        tbl[6]  = '{1, 5'd9, 32'h101,      0, 5'd0, 32'h0,  1, 1, 1, 5'd9, 32'h101,      2'd1};
        tbl[7]  = '{1, 5'd9, 32'h102,      0, 5'd0, 32'h0,  1, 1, 1, 5'd9, 32'h102,      2'd1};
        tbl[8]  = '{1, 5'd9, 32'h103,      0, 5'd0, 32'h0,  1, 1, 1, 5'd9, 32'h103,      2'd1};
        tbl[9]  = '{1, 5'd9, 32'h104,      0, 5'd0, 32'h0,  1, 1, 1, 5'd9, 32'h104,      2'd1};
        tbl[10] = '{1, 5'd9, 32'h105,      0, 5'd0, 32'h0,  0, 1, 1, 5'd3, 32'h33,       2'd0};
        tbl[11] = '{1, 5'd9, 32'h105,      0, 5'd0, 32'h0,  1, 1, 1, 5'd9, 32'h105,      2'd0};
        tbl[12] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  1, 1, 0, 5'd9, 32'h105,      2'd0};

        do_reset();
        foreach (tbl[i]) begin
            a_valid = tbl[i].av; a_addr = tbl[i].aa; a_data = tbl[i].ad;
            b_valid = tbl[i].bv; b_addr = tbl[i].ba; b_data = tbl[i].bd;
            #4;
            chk($sformatf("vec%0d_a_ready", i), a_ready, tbl[i].ar);
            chk($sformatf("vec%0d_b_ready", i), b_ready, tbl[i].br);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_we", i), rf_we, tbl[i].we);
            chk($sformatf("vec%0d_wa", i), rf_wa, tbl[i].wa);
            chk($sformatf("vec%0d_wd", i), rf_wd, tbl[i].wd);
            chk($sformatf("vec%0d_pend", i), b_pending, tbl[i].pend);
        end

        // Squash: A to addr 4 kills the pending B entry for addr 4.
        do_reset();
        step(0, 0, 0, 1, 5'd4, 32'h55);
        step(1, 5'd4, 32'hAA, 0, 0, 0);
        chk("squash_a_wd", rf_wd, 32'hAA);
        step(0, 0, 0, 0, 0, 0);
        chk("squash_pop_we", rf_we, 0);
        chk("squash_pend", b_pending, 0);

        // Full FIFO with A held: third push waits for a pop, B order kept.
        do_reset();
        wlog.delete();
        step(1, 5'd10, 32'hA0, 1, 5'd1, 32'h1);
        step(1, 5'd10, 32'hA1, 1, 5'd2, 32'h2);
        chk("full_pend", b_pending, 2);
        accepted = 0;
        for (int k = 0; k < 20 && !accepted; k++) begin
            accepted = (q.size() < DEPTH);
            if (k == 0) chk("full_first_refused", accepted, 0);
            step(1, 5'd10, 32'hA2 + k, 1, 5'd3, 32'h3);
        end
        chk("full_push_accepted", accepted, 1);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0, 0);
        foreach (wlog[i]) if (wlog[i] < 32'h10) bw.push_back(wlog[i]);
        chk("order_cnt", bw.size(), 3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("order%0d", i), (i < bw.size()) ? bw[i] : 32'hFFFF_FFFF, i + 1);

        // Address 0 writes are consumed silently.
        do_reset();
        step(1, 5'd0, 32'h77, 0, 0, 0);
        chk("a_addr0_we", rf_we, 0);
        step(0, 0, 0, 1, 5'd0, 32'h88);
        step(0, 0, 0, 0, 0, 0);
        chk("b_addr0_we", rf_we, 0);
        chk("b_addr0_pend", b_pending, 0);

        // Mid-operation asynchronous reset discards pending entries.
        step(1, 5'd12, 32'hC0, 1, 5'd5, 32'h5);
        step(1, 5'd12, 32'hC1, 1, 5'd6, 32'h6);
        chk("pre_rst_pend", b_pending, 2);
        a_valid = 0; b_valid = 0;
        #3 rst = 1'b1;
        #1;
        chk("async_rst_pend", b_pending, 0);
        chk("async_rst_we", rf_we, 0);
        chk("async_rst_a_ready", a_ready, 1);
        chk("async_rst_b_ready", b_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 0, 0, 0, 0);
            chk("post_rst_we", rf_we, 0);
        end

        // Random traffic against the model; small address range forces squashes.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 99) < 55, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 99) < 45, 5'($urandom_range(0, 7)), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
